// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder.
// Contents: op_type codes, MIPS opcode/funct constants, the session FSM state enum
// and a helper that builds an R-type word.
package instr_encoder_pkg;

    // op_type codes presented on the field-bundle interface
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_LW  = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_J   = 4'b1001;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // R-type funct field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // R-type layout: opcode | rs | rt | rd | shamt(0) | funct
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, fn};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op_type plus register/immediate/target fields -> 32-bit MIPS word.
// Ports: op_type_i, rs_i, rt_i, rd_i, imm_i, target_i in; word_o (encoded word), illegal_o
// (op_type unsupported; word_o is then all zeros, i.e. a nop).
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op_type_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_type_i)
            OP_ADD:  word_o = rtype(rs_i, rt_i, rd_i, FN_ADD);
            OP_SUB:  word_o = rtype(rs_i, rt_i, rd_i, FN_SUB);
            OP_AND:  word_o = rtype(rs_i, rt_i, rd_i, FN_AND);
            OP_OR:   word_o = rtype(rs_i, rt_i, rd_i, FN_OR);
            OP_SLT:  word_o = rtype(rs_i, rt_i, rd_i, FN_SLT);
            OP_LW:   word_o = {OPC_LW,  rs_i, rt_i, imm_i};
            OP_SW:   word_o = {OPC_SW,  rs_i, rt_i, imm_i};
            OP_BEQ:  word_o = {OPC_BEQ, rs_i, rt_i, imm_i};
            OP_J:    word_o = {OPC_J, target_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Session-based MIPS encoder: accepts field bundles, emits encoded words with sequential
// word addresses starting at base_addr. Latency 1 cycle, full throughput; in_ready drops
// while an unaccepted word is held. Ports: clk, rst (sync, active-high), start/stop/base_addr
// session control, in_valid/in_ready + fields, out_valid/out_ready/out_instr/out_addr, busy, illegal.
// Build option ENC_ILLEGAL_NOP_EN: illegal ops emit a nop and consume an address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_type,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [31:0]       instr_q, instr_d;
    logic              ill_q, ill_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        in_fire, out_fire, emit;

    instr_pack u_pack (
        .op_type_i (op_type),
        .rs_i      (rs),
        .rt_i      (rt),
        .rd_i      (rd),
        .imm_i     (imm),
        .target_i  (target),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    // Output register may reload in the same cycle it is drained, so ready looks through it.
    assign in_ready = (state_q == ST_RUN) && (!vld_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_q && out_ready;

`ifdef ENC_ILLEGAL_NOP_EN
    // Illegal ops still produce a word; pack_word is already zero (nop) for them.
    assign emit = in_fire;
`else
    assign emit = in_fire && !pack_illegal;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        ill_d   = ill_q;

        // The counter always names the address of the word currently held, so it
        // advances when that word leaves.
        if (out_fire) begin
            cnt_d = cnt_q + 1'b1;
            vld_d = 1'b0;
        end
        if (emit) begin
            vld_d   = 1'b1;
            instr_d = pack_word;
        end
        if (in_fire && pack_illegal) begin
            ill_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = base_addr;
                    ill_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!vld_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            instr_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid = vld_q;
    assign out_instr = instr_q;
    assign out_addr  = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign illegal   = ill_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8; instruction-memory word-address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  begin a session at base_addr; ignored unless IDLE.
REQ-005 stop  input  1  end session after the pending output drains.
REQ-006 base_addr  input  ADDR_W  first write address of a session.
REQ-007 in_valid / in_ready  input / output  1 / 1  field-bundle handshake.
REQ-008 op_type  input  4  0001 add, 0010 sub, 0011 and, 0100 or, 0101 slt, 0110 lw, 0111 sw, 1000 beq, 1001 j.
REQ-009 rs, rt, rd  input  5 each  register fields.
REQ-010 imm  input  16  immediate or branch offset.
REQ-011 target  input  26  jump target.
REQ-012 out_valid / out_ready  output / input  1 / 1  encoded-word handshake.
REQ-013 out_instr  output  32  encoded MIPS word.
REQ-014 out_addr  output  ADDR_W  memory word address for out_instr.
REQ-015 busy  output  1  high when not IDLE.
REQ-016 illegal  output  1  sticky flag; set when an unsupported op_type is accepted.

Function
REQ-017 States: IDLE, RUN, DRAIN.
- IDLE->RUN on start; addr counter loads base_addr.
- RUN->DRAIN on stop.
- DRAIN->IDLE once out_valid is 0.
REQ-018 in_ready = (state==RUN) and (out_valid==0 or out_ready==1); in_ready is 0 in IDLE and DRAIN.
REQ-019 An input transfer (in_valid & in_ready) at edge N registers the word, so out_valid is 1 from cycle N+1: latency 1, full throughput.
REQ-020 R-type encoding: opcode 000000, rs, rt, rd, shamt 00000, funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
REQ-021 I-type encoding: opcode lw 100011, sw 101011, beq 000100, followed by rs, rt, imm.
REQ-022 J-type encoding: opcode 000010, followed by target; unused fields are ignored.
REQ-023 op_type 0000 or 1010-1111 is illegal: the bundle is consumed and illegal is set; emission follows REQ-031.
REQ-024 While out_valid=1 and out_ready=0, out_instr and out_addr stay stable.
REQ-025 out_addr is the counter value; the counter increments on each output transfer and wraps from 2^ADDR_W-1 to 0.
REQ-026 A simultaneous output transfer and input transfer in the same cycle reloads the register with no bubble.
REQ-027 stop and an input transfer in the same cycle: the input is accepted, then the state moves to DRAIN.
REQ-028 start while in RUN or DRAIN has no effect.
REQ-029 illegal clears only on rst or on a start accepted in IDLE.

Reset
REQ-030 On rst:
- state goes to IDLE; the counter is 0.
- out_valid, busy, illegal and in_ready are 0; out_instr and out_addr are 0.
- a pending word is discarded, including mid-session.

Configuration
REQ-031 Macro ENC_ILLEGAL_NOP_EN:
- defined: an illegal op emits 32'h00000000 (nop) and consumes an address.
- undefined: an illegal op emits nothing and the counter is unchanged.
- illegal is set in both cases.

Structure
REQ-032 Shared package holds:
- op_type codes;
- opcode and funct constants;
- state enum.
REQ-033 Sub-module instr_pack: combinational op_type and fields to 32-bit word plus illegal bit; the wrapper holds the FSM, counter and output register.

Verification
REQ-034 start with base 0x10, then add rs=1 rt=2 rd=3 -> out_instr 0x00221820, out_addr 0x10, valid one cycle after acceptance.
REQ-035 lw rs=29 rt=8 imm=4, then j target=0x10, back-to-back with out_ready=1 -> 0x8FA80004 @0x10, then 0x08000010 @0x11, no bubble.
REQ-036 out_ready held low for 3 cycles -> out_instr and out_addr stable, in_ready 0, counter unchanged; release -> next address.
REQ-037 ADDR_W=2, base 3, two sw words -> addresses 3, then 0.
REQ-038 op_type 1111 -> illegal=1; no output without the macro; 0x00000000 at the next address with the macro.
REQ-039 rst asserted with out_valid=1 in RUN -> next cycle IDLE, out_valid 0, busy 0; stop -> DRAIN -> IDLE after the last transfer.
